uart_receiver: RTL and testbench

Serial-to-parallel UART receive stage, directly downstream of the baud-rate generator. Consumes the oversampled receive tick, synchronises the asynchronous `rx` line, detects and validates start bits, majority-votes each bit at mid-period, and presents one received byte per frame with valid and error strobes. All logic runs in the single system clock domain; the tick is a clock-enable, never a clock.

---
 rtl/uart_receiver_pkg.sv | 26 ++
 rtl/uart_receiver_if.sv | 22 ++
 rtl/uart_receiver_rx_sync.sv | 22 ++
 rtl/uart_receiver.sv | 123 ++++++++++++
 tb/tb_uart_receiver.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_receiver_pkg.sv
// Shared constants and types for the UART receive path: parity modes,
// receiver state encodings and the bit-vote helper.
package uart_receiver_pkg;

    localparam int OVERSAMPLING_16 = 16;

    typedef enum logic [1:0] {
        PARITY_NONE,
        PARITY_ODD,
        PARITY_EVEN
    } parity_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_IDLE
    } rx_state_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// Receiver-side bus: tick enable and serial line in, byte and strobes out.
interface uart_receiver_if #(
    parameter int DATA_BITS = 8
);
    logic                 rxTick;
    logic                 rx;
    logic [DATA_BITS-1:0] data;
    logic                 dataValid;
    logic                 parityError;
    logic                 frameError;
    logic                 busy;

    modport master (
        input  rxTick, rx,
        output data, dataValid, parityError, frameError, busy
    );

    modport slave (
        output rxTick, rx,
        input  data, dataValid, parityError, frameError, busy
    );
endinterface

// File: rtl/uart_receiver_rx_sync.sv
// Two-flop synchroniser for the asynchronous rx line, with a
// parameterised reset value so an idle-high line never looks like a start bit.
module uart_receiver_rx_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/uart_receiver.sv
// UART receive stage: synchronises rx, validates the start bit, majority-votes
// every bit around mid-period and emits one byte per frame with strobes.
module uart_receiver
    import uart_receiver_pkg::*;
#(
    parameter int      DATA_BITS    = 8,
    parameter int      OVERSAMPLING = OVERSAMPLING_16,
    parameter parity_t PARITY       = PARITY_NONE
) (
    input logic             clk,
    input logic             reset,
    uart_receiver_if.master bus
);
    localparam int CW = $clog2(OVERSAMPLING);
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [CW-1:0] VOTE_A   = CW'(OVERSAMPLING / 2 - 1);
    localparam logic [CW-1:0] VOTE_B   = CW'(OVERSAMPLING / 2);
    localparam logic [CW-1:0] VOTE_C   = CW'(OVERSAMPLING / 2 + 1);
    localparam logic [CW-1:0] S_LAST   = CW'(OVERSAMPLING - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    rx_state_t            state, state_nxt;
    logic                 rx_s;
    logic [CW-1:0]        s_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [1:0]           samp;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_err;
    logic                 vote, at_dec, at_end, counting;
    logic                 load_data, valid_nxt, perr_nxt, ferr_nxt;

    uart_receiver_rx_sync #(.RESET_VAL(1'b1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (bus.rx),
        .q     (rx_s)
    );

    // The third sample is the live one; the decision lands on VOTE_C.
    assign vote     = majority3(samp[0], samp[1], rx_s);
    assign at_dec   = (s_cnt == VOTE_C);
    assign at_end   = (s_cnt == S_LAST);
    assign counting = state inside {ST_START, ST_DATA, ST_PARITY, ST_STOP};
    assign bus.busy = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (bus.rxTick) begin
            case (state)
                ST_IDLE:      if (!rx_s) state_nxt = ST_START;
                ST_START: begin
                    if (at_dec && vote) state_nxt = ST_IDLE;
                    else if (at_end)    state_nxt = ST_DATA;
                end
                ST_DATA: begin
                    if (at_end && bit_cnt == LAST_BIT)
                        state_nxt = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                end
                ST_PARITY:    if (at_end) state_nxt = ST_STOP;
                // A good stop bit returns to IDLE at mid-bit so the next
                // start edge can follow with no idle gap.
                ST_STOP:      if (at_dec) state_nxt = vote ? ST_IDLE : ST_WAIT_IDLE;
                ST_WAIT_IDLE: if (rx_s) state_nxt = ST_IDLE;
                default:      state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        load_data = 1'b0;
        valid_nxt = 1'b0;
        perr_nxt  = 1'b0;
        ferr_nxt  = 1'b0;
        if (bus.rxTick && state == ST_STOP && at_dec) begin
            load_data = 1'b1;
            if (vote) begin
                valid_nxt = 1'b1;
                perr_nxt  = par_err;
            end else begin
                ferr_nxt  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s_cnt           <= '0;
            bit_cnt         <= '0;
            samp            <= '0;
            shreg           <= '0;
            par_err         <= 1'b0;
            bus.data        <= '0;
            bus.dataValid   <= 1'b0;
            bus.parityError <= 1'b0;
            bus.frameError  <= 1'b0;
        end else begin
            bus.dataValid   <= valid_nxt;
            bus.parityError <= perr_nxt;
            bus.frameError  <= ferr_nxt;
            if (load_data) bus.data <= shreg;
            if (bus.rxTick) begin
                s_cnt <= (counting && state_nxt == state && !at_end) ? s_cnt + 1'b1 : '0;
                if (s_cnt == VOTE_A) samp[0] <= rx_s;
                if (s_cnt == VOTE_B) samp[1] <= rx_s;
                if (state == ST_IDLE && !rx_s) begin
                    bit_cnt <= '0;
                    par_err <= 1'b0;
                end
                if (state == ST_DATA && at_dec) shreg <= {vote, shreg[DATA_BITS-1:1]};
                if (state == ST_DATA && at_end) bit_cnt <= bit_cnt + 1'b1;
                // Total ones over payload plus parity bit must be even (or odd).
                if (state == ST_PARITY && at_dec)
                    par_err <= (^shreg) ^ vote ^ (PARITY == PARITY_ODD);
            end
        end
    end
endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: one no-parity and one even-parity receiver, each
// fed frames built bit by bit; strobes are collected and compared to a frame model.
module tb_uart_receiver;
    import uart_receiver_pkg::*;

    typedef struct packed {
        logic [7:0] data;
        logic       valid;
        logic       perr;
        logic       ferr;
    } rec_t;

    logic clk;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    rec_t q0[$];
    rec_t q1[$];

    uart_receiver_if #(.DATA_BITS(8)) b0 ();
    uart_receiver_if #(.DATA_BITS(8)) b1 ();

    uart_receiver #(.DATA_BITS(8), .OVERSAMPLING(16), .PARITY(PARITY_NONE)) dut0 (
        .clk(clk), .reset(reset), .bus(b0)
    );
    uart_receiver #(.DATA_BITS(8), .OVERSAMPLING(16), .PARITY(PARITY_EVEN)) dut1 (
        .clk(clk), .reset(reset), .bus(b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One tick every 4 clk, changed just after the edge.
    initial begin
        b0.rxTick = 1'b0;
        b1.rxTick = 1'b0;
        forever begin
            repeat (3) @(posedge clk);
            #1;
            b0.rxTick = 1'b1;
            b1.rxTick = 1'b1;
            @(posedge clk);
            #1;
            b0.rxTick = 1'b0;
            b1.rxTick = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (b0.dataValid || b0.parityError || b0.frameError)
            q0.push_back('{b0.data, b0.dataValid, b0.parityError, b0.frameError});
        if (b1.dataValid || b1.parityError || b1.frameError)
            q1.push_back('{b1.data, b1.dataValid, b1.parityError, b1.frameError});
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "time limit");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick_wait(input int n);
        int k = 0;
        while (k < n) begin
            @(posedge clk);
            if (b0.rxTick) k++;
        end
        #1;
    endtask

    task automatic drive(input bit sel, input logic v);
        if (sel) b1.rx = v;
        else     b0.rx = v;
    endtask

    task automatic send_frame(input bit sel, input logic [7:0] d, input bit has_par,
                              input logic pbit, input logic stop);
        drive(sel, 1'b0);
        tick_wait(16);
        for (int i = 0; i < 8; i++) begin
            drive(sel, d[i]);
            tick_wait(16);
        end
        if (has_par) begin
            drive(sel, pbit);
            tick_wait(16);
        end
        drive(sel, stop);
        tick_wait(16);
    endtask

    // What a frame should produce, from the line-level rules: a high stop bit
    // delivers the byte; even parity means an even count of ones overall.
    function automatic rec_t model(input logic [7:0] d, input bit has_par,
                                   input logic pbit, input logic stop);
        rec_t r;
        int   ones;
        ones   = $countones(d) + ((has_par && pbit) ? 1 : 0);
        r.data  = d;
        r.valid = stop;
        r.ferr  = !stop;
        r.perr  = stop && has_par && (ones % 2 != 0);
        return r;
    endfunction

    task automatic compare_rec(input string tag, input rec_t got, input rec_t exp);
        check({tag, "_data"},  got.data,  exp.data);
        check({tag, "_valid"}, got.valid, exp.valid);
        check({tag, "_perr"},  got.perr,  exp.perr);
        check({tag, "_ferr"},  got.ferr,  exp.ferr);
    endtask

    task automatic expect_frame(input bit sel, input string tag, input rec_t exp);
        rec_t got;
        int   n;
        n = sel ? q1.size() : q0.size();
        check({tag, "_count"}, n, 1);
        if (n > 0) begin
            got = sel ? q1.pop_front() : q0.pop_front();
            compare_rec(tag, got, exp);
        end
        if (sel) q1.delete();
        else     q0.delete();
    endtask

    initial begin
        logic [7:0] d;
        logic [7:0] b55;
        bit         sel;
        logic       pbit, stop;
        rec_t       got;

        reset = 1'b1;
        b0.rx = 1'b1;
        b1.rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_data",  b0.data, 8'h00);
        check("rst_valid", b0.dataValid, 1'b0);
        check("rst_perr",  b0.parityError, 1'b0);
        check("rst_ferr",  b0.frameError, 1'b0);
        check("rst_busy",  b0.busy, 1'b0);
        check("rst_busy1", b1.busy, 1'b0);
        tick_wait(4);

        send_frame(0, 8'hA5, 0, 1'b0, 1'b1);
        expect_frame(0, "a5", model(8'hA5, 0, 1'b0, 1'b1));
        check("a5_busy", b0.busy, 1'b0);

        // Short low pulse on the line: start rejected, no strobes.
        drive(0, 1'b0);
        tick_wait(3);
        check("glitch_busy_hi", b0.busy, 1'b1);
        tick_wait(2);
        drive(0, 1'b1);
        tick_wait(8);
        check("glitch_busy_lo", b0.busy, 1'b0);
        check("glitch_nostrobe", q0.size(), 0);

        send_frame(0, 8'h3C, 0, 1'b0, 1'b0);
        tick_wait(24);
        expect_frame(0, "ferr", model(8'h3C, 0, 1'b0, 1'b0));
        check("ferr_data_hold", b0.data, 8'h3C);
        check("ferr_busy_break", b0.busy, 1'b1);
        drive(0, 1'b1);
        tick_wait(1);
        check("ferr_busy_clear", b0.busy, 1'b0);
        tick_wait(2);

        send_frame(1, 8'h3C, 1, 1'b1, 1'b1);
        expect_frame(1, "par1", model(8'h3C, 1, 1'b1, 1'b1));
        send_frame(1, 8'h3C, 1, 1'b0, 1'b1);
        expect_frame(1, "par0", model(8'h3C, 1, 1'b0, 1'b1));

        send_frame(0, 8'h00, 0, 1'b0, 1'b1);
        send_frame(0, 8'hFF, 0, 1'b0, 1'b1);
        check("b2b_count", q0.size(), 2);
        if (q0.size() >= 2) begin
            got = q0.pop_front();
            compare_rec("b2b_first", got, model(8'h00, 0, 1'b0, 1'b1));
            got = q0.pop_front();
            compare_rec("b2b_second", got, model(8'hFF, 0, 1'b0, 1'b1));
        end
        q0.delete();

        // Reset in the middle of data bit 3.
        b55 = 8'h55;
        drive(0, 1'b0);
        tick_wait(16);
        for (int i = 0; i < 3; i++) begin
            drive(0, b55[i]);
            tick_wait(16);
        end
        drive(0, b55[3]);
        tick_wait(8);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive(0, 1'b1);
        check("mrst_data",  b0.data, 8'h00);
        check("mrst_valid", b0.dataValid, 1'b0);
        check("mrst_perr",  b0.parityError, 1'b0);
        check("mrst_ferr",  b0.frameError, 1'b0);
        check("mrst_busy",  b0.busy, 1'b0);
        tick_wait(20);
        check("mrst_nostrobe", q0.size(), 0);
        send_frame(0, 8'h81, 0, 1'b0, 1'b1);
        expect_frame(0, "post_rst", model(8'h81, 0, 1'b0, 1'b1));

        for (int n = 0; n < 16; n++) begin
            sel  = 1'($urandom_range(0, 1));
            d    = 8'($urandom);
            pbit = 1'($urandom_range(0, 1));
            stop = ($urandom_range(0, 3) != 0);
            send_frame(sel, d, sel, pbit, stop);
            if (!stop) begin
                drive(sel, 1'b1);
                tick_wait(2);
            end
            expect_frame(sel, $sformatf("rand%0d", n), model(d, sel, pbit, stop));
            check($sformatf("rand%0d_busy", n), sel ? b1.busy : b0.busy, 1'b0);
            tick_wait($urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
